// File: rtl/pio_edge_event_sequencer_if.sv
// Bus bundle for pio_edge_event_sequencer: Avalon-MM master to the PIO, software slave port and irq.
// "master" is the sequencer's view; "slave" is the view of the PIO/software side.
interface pio_edge_event_sequencer_if;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic [2:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    modport master (
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_readdata,
        input  s_address, s_read, s_write, s_writedata,
        output s_readdata, irq
    );

    modport slave (
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_readdata,
        output s_address, s_read, s_write, s_writedata,
        input  s_readdata, irq
    );
endinterface

// File: rtl/pio_edge_event_sequencer.sv
// Polls an edge-capturing PIO, reads/clears it and queues {mask, data, timestamp} events for software.
// Optional macro PIO_SEQ_TIMESTAMP_EN adds a free-running 32-bit timestamp stored with each event.
module pio_edge_event_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int POLL_DIV   = 16,
    parameter int CNT_W      = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pio_edge_event_sequencer_if.master bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int TW  = $clog2(POLL_DIV);
    localparam logic [AW:0]   DEPTH_C = AW1'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX_C  = TW'(POLL_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_CAP = 3'd1,
        S_W_CAP  = 3'd2,
        S_RD_DAT = 3'd3,
        S_W_DAT  = 3'd4,
        S_CLR    = 3'd5,
        S_PUSH   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ctrl_en_q, ctrl_en_d, ctrl_irq_en_q, ctrl_irq_en_d, ovf_q, ovf_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]   cap_q, cap_d, dat_q, dat_d;
    logic          m_cs_q, m_cs_d, m_wn_q, m_wn_d, irq_q, irq_d;
    logic [1:0]    m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d, s_rdata_q, s_rdata_d, rd_mux_s;
    logic [31:0]   mem_cap_q [FIFO_DEPTH];
    logic [31:0]   mem_dat_q [FIFO_DEPTH];
    logic          poll_s, flush_s, empty_s, full_s, pop_s, push_s, push_ok_s, mem_we_s;
    logic          sig_unused_s;

    assign poll_s    = ctrl_en_q && (timer_q == TMAX_C);
    assign flush_s   = bus.s_write && (bus.s_address == 3'd0) && bus.s_writedata[2];
    assign empty_s   = (cnt_q == AW1'(0));
    assign full_s    = (cnt_q == DEPTH_C);
    assign pop_s     = bus.s_read && (bus.s_address == 3'd4) && !empty_s;
    assign push_s    = (state_q == S_PUSH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign mem_we_s  = push_ok_s && !flush_s;
    assign sig_unused_s = ^bus.s_writedata[30:3];

    assign bus.m_address    = m_addr_q;
    assign bus.m_chipselect = m_cs_q;
    assign bus.m_write_n    = m_wn_q;
    assign bus.m_writedata  = m_wdata_q;
    assign bus.s_readdata   = s_rdata_q;
    assign bus.irq          = irq_q;

`ifdef PIO_SEQ_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d, ts_lat_q, ts_lat_d;
    logic [31:0] mem_ts_q [FIFO_DEPTH];

    // Free-running timestamp and its per-poll sample taken alongside the capture mask.
    always_comb begin
        ts_d = ts_q + 32'd1;
        if (state_q == S_W_CAP) ts_lat_d = ts_q;
        else                    ts_lat_d = ts_lat_q;
    end

    // Timestamp registers and per-entry timestamp storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q     <= 32'd0;
            ts_lat_q <= 32'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_ts_q[i] <= 32'd0;
        end else begin
            ts_q     <= ts_d;
            ts_lat_q <= ts_lat_d;
            if (mem_we_s) mem_ts_q[wr_ptr_q] <= ts_lat_q;
        end
    end
`endif

    // Poll sequencer next state, data latches and registered master strobes.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        dat_d   = dat_q;
        if (ctrl_en_q) timer_d = (timer_q == TMAX_C) ? TW'(0) : timer_q + TW'(1);
        else           timer_d = TW'(0);
        case (state_q)
            S_IDLE:   if (poll_s) state_d = S_RD_CAP; else state_d = S_IDLE;
            S_RD_CAP: state_d = S_W_CAP;
            S_W_CAP: begin
                cap_d = bus.m_readdata;
                if (bus.m_readdata == 32'd0) state_d = S_IDLE;
                else                         state_d = S_RD_DAT;
            end
            S_RD_DAT: state_d = S_W_DAT;
            S_W_DAT: begin
                dat_d   = bus.m_readdata;
                state_d = S_CLR;
            end
            S_CLR:    state_d = S_PUSH;
            S_PUSH:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        m_cs_d    = 1'b0;
        m_addr_d  = 2'd0;
        m_wn_d    = 1'b1;
        m_wdata_d = 32'd0;
        case (state_d)
            S_RD_CAP: begin
                m_cs_d   = 1'b1;
                m_addr_d = 2'd3;
            end
            S_RD_DAT: m_cs_d = 1'b1;
            S_CLR: begin
                m_cs_d    = 1'b1;
                m_addr_d  = 2'd3;
                m_wn_d    = 1'b0;
                m_wdata_d = 32'hFFFF_FFFF;
            end
            default:  m_cs_d = 1'b0;
        endcase
    end

    // Control register, sticky overflow and FIFO pointer/count bookkeeping.
    always_comb begin
        ctrl_en_d     = ctrl_en_q;
        ctrl_irq_en_d = ctrl_irq_en_q;
        ovf_d         = ovf_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (bus.s_write && (bus.s_address == 3'd0)) begin
            ctrl_en_d     = bus.s_writedata[0];
            ctrl_irq_en_d = bus.s_writedata[1];
        end else begin
            ctrl_en_d     = ctrl_en_q;
        end
        if (bus.s_write && (bus.s_address == 3'd1) && bus.s_writedata[31]) ovf_d = 1'b0;
        else                                                             ovf_d = ovf_q;
        if (flush_s) begin
            cnt_d    = AW1'(0);
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
        end else begin
            if (push_s && !push_ok_s) ovf_d = 1'b1;
            else                      ovf_d = ovf_d;
            if (push_ok_s) wr_ptr_d = wr_ptr_q + AW'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
            else       rd_ptr_d = rd_ptr_q;
            cnt_d = cnt_q + AW1'(push_ok_s) - AW1'(pop_s);
        end
    end

    // Software register read mux; head fields read 0 while the FIFO is empty.
    always_comb begin
        rd_mux_s = 32'd0;
        case (bus.s_address)
            3'd0: rd_mux_s = {30'd0, ctrl_irq_en_q, ctrl_en_q};
            3'd1: begin
                rd_mux_s[CNT_W-1:0] = CNT_W'(cnt_q);
                rd_mux_s[16]        = empty_s;
                rd_mux_s[17]        = full_s;
                rd_mux_s[31]        = ovf_q;
            end
            3'd2: rd_mux_s = empty_s ? 32'd0 : mem_cap_q[rd_ptr_q];
            3'd3: rd_mux_s = empty_s ? 32'd0 : mem_dat_q[rd_ptr_q];
`ifdef PIO_SEQ_TIMESTAMP_EN
            3'd4: rd_mux_s = empty_s ? 32'd0 : mem_ts_q[rd_ptr_q];
`else
            3'd4: rd_mux_s = 32'd0;
`endif
            default: rd_mux_s = 32'd0;
        endcase
        if (bus.s_read) s_rdata_d = rd_mux_s;
        else            s_rdata_d = s_rdata_q;
        irq_d = ctrl_irq_en_q & ~empty_s;
    end

    // State, control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= TW'(0);
            ctrl_en_q     <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            ovf_q         <= 1'b0;
            cnt_q         <= AW1'(0);
            wr_ptr_q      <= AW'(0);
            rd_ptr_q      <= AW'(0);
            cap_q         <= 32'd0;
            dat_q         <= 32'd0;
            m_cs_q        <= 1'b0;
            m_addr_q      <= 2'd0;
            m_wn_q        <= 1'b1;
            m_wdata_q     <= 32'd0;
            s_rdata_q     <= 32'd0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ctrl_en_q     <= ctrl_en_d;
            ctrl_irq_en_q <= ctrl_irq_en_d;
            ovf_q         <= ovf_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cap_q         <= cap_d;
            dat_q         <= dat_d;
            m_cs_q        <= m_cs_d;
            m_addr_q      <= m_addr_d;
            m_wn_q        <= m_wn_d;
            m_wdata_q     <= m_wdata_d;
            s_rdata_q     <= s_rdata_d;
            irq_q         <= irq_d;
        end
    end

    // Event storage for mask and data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_cap_q[i] <= 32'd0;
                mem_dat_q[i] <= 32'd0;
            end
        end else if (mem_we_s) begin
            mem_cap_q[wr_ptr_q] <= cap_q;
            mem_dat_q[wr_ptr_q] <= dat_q;
        end
    end
endmodule
